// File: rtl/alu_result_stage.sv
// Post-ALU stage: evaluates the condition code against the committed NZCV, updates flags,
// and forwards write-back packets through an output register backed by a one-entry skid.
module alu_result_stage #(
    parameter int unsigned M = 32,
    parameter int unsigned R = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [M-1:0] in_y,
    input  logic [3:0]   in_flags,
    input  logic [3:0]   in_cond,
    input  logic         in_setf,
    input  logic         in_wb,
    input  logic [R-1:0] in_rd,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [M-1:0] out_y,
    output logic [R-1:0] out_rd,
    output logic         out_we,
    output logic         out_pass,
    output logic [3:0]   nzcv
);

    typedef struct packed {
        logic [M-1:0] y;
        logic [R-1:0] rd;
        logic         we;
        logic         pass;
    } pkt_t;

    pkt_t out_q;
    pkt_t skid_q;
    pkt_t in_pkt;
    logic skid_valid;
    logic accept;
    logic pass;
    logic flag_n;
    logic flag_z;
    logic flag_c;
    logic flag_v;

    assign flag_n = nzcv[3];
    assign flag_z = nzcv[2];
    assign flag_c = nzcv[1];
    assign flag_v = nzcv[0];

    // Condition evaluation against the committed status register
    always_comb begin
        pass = 1'b0;
        case (in_cond)
            4'h0: pass = flag_z;
            4'h1: pass = ~flag_z;
            4'h2: pass = flag_c;
            4'h3: pass = ~flag_c;
            4'h4: pass = flag_n;
            4'h5: pass = ~flag_n;
            4'h6: pass = flag_v;
            4'h7: pass = ~flag_v;
            4'h8: pass = flag_c & ~flag_z;
            4'h9: pass = ~flag_c | flag_z;
            4'hA: pass = (flag_n == flag_v);
            4'hB: pass = (flag_n != flag_v);
            4'hC: pass = ~flag_z & (flag_n == flag_v);
            4'hD: pass = flag_z | (flag_n != flag_v);
            4'hE: pass = 1'b1;
            4'hF: pass = 1'b0;
            default: pass = 1'b0;
        endcase
    end

    // Accepting never depends on out_ready: only a full skid or a flush blocks the producer
    assign in_ready = ~skid_valid & ~flush;
    assign accept   = in_valid & in_ready;

    always_comb begin
        in_pkt.y    = in_y;
        in_pkt.rd   = in_rd;
        in_pkt.we   = in_wb & pass;
        in_pkt.pass = pass;
    end

    // Status register; an accepted packet's update is visible to the very next packet
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nzcv <= 4'b0000;
        end else if (accept && pass && in_setf) begin
            nzcv <= in_flags;
        end
    end

    // Output register plus skid entry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
            out_q      <= '0;
            skid_q     <= '0;
        end else if (flush) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
        end else if (!out_valid || out_ready) begin
            if (skid_valid) begin
                out_q      <= skid_q;
                out_valid  <= 1'b1;
                skid_valid <= 1'b0;
            end else if (accept) begin
                out_q     <= in_pkt;
                out_valid <= 1'b1;
            end else begin
                out_valid <= 1'b0;
            end
        end else if (accept) begin
            skid_q     <= in_pkt;
            skid_valid <= 1'b1;
        end
    end

    assign out_y    = out_q.y;
    assign out_rd   = out_q.rd;
    assign out_we   = out_q.we;
    assign out_pass = out_q.pass;

endmodule

// File: tb/tb_alu_result_stage.sv
// Bench for alu_result_stage: directed scenarios plus random traffic, checked against
// a queue-based reference model of the two-entry buffer and an ARM-style condition table.
module tb_alu_result_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_y;
    logic [3:0]  in_flags;
    logic [3:0]  in_cond;
    logic        in_setf;
    logic        in_wb;
    logic [3:0]  in_rd;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_y;
    logic [3:0]  out_rd;
    logic        out_we;
    logic        out_pass;
    logic [3:0]  nzcv;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        logic [31:0] y;
        logic [3:0]  rd;
        logic        we;
        logic        pass;
    } pkt_t;

    pkt_t       m_q[$];
    logic [3:0] m_nzcv;

    alu_result_stage #(.M(32), .R(4)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_y(in_y), .in_flags(in_flags),
        .in_cond(in_cond), .in_setf(in_setf), .in_wb(in_wb), .in_rd(in_rd),
        .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y), .out_rd(out_rd),
        .out_we(out_we), .out_pass(out_pass), .nzcv(nzcv)
    );

    always #5 clk = ~clk;

    // Odd codes are the negation of the even code below them; 0xE is "always"
    function automatic bit cond_m(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cc, v, b;
        n = f[3]; z = f[2]; cc = f[1]; v = f[0];
        case (c[3:1])
            3'd0: b = z;
            3'd1: b = cc;
            3'd2: b = n;
            3'd3: b = v;
            3'd4: b = cc && !z;
            3'd5: b = (n == v);
            3'd6: b = !z && (n == v);
            default: b = 1'b1;
        endcase
        return b ^ c[0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: drive at negedge, compare DUT with model, advance model at posedge
    task automatic tick(input logic v, input logic [31:0] y, input logic [3:0] f,
                        input logic [3:0] c, input logic s, input logic w,
                        input logic [3:0] rd, input logic ordy, input logic fl);
        bit   exp_ready, acc, ps;
        pkt_t p;
        @(negedge clk);
        in_valid = v; in_y = y; in_flags = f; in_cond = c; in_setf = s;
        in_wb = w; in_rd = rd; out_ready = ordy; flush = fl;
        #1;
        exp_ready = (m_q.size() < 2) && !fl;
        chk("in_ready", 32'(in_ready), 32'(exp_ready));
        chk("out_valid", 32'(out_valid), 32'(m_q.size() > 0));
        chk("nzcv", 32'(nzcv), 32'(m_nzcv));
        if (m_q.size() > 0) begin
            chk("out_y", out_y, m_q[0].y);
            chk("out_rd", 32'(out_rd), 32'(m_q[0].rd));
            chk("out_we", 32'(out_we), 32'(m_q[0].we));
            chk("out_pass", 32'(out_pass), 32'(m_q[0].pass));
        end
        acc = v && exp_ready;
        ps  = cond_m(c, m_nzcv);
        @(posedge clk);
        if (fl) begin
            m_q.delete();
        end else begin
            if (m_q.size() > 0 && ordy) void'(m_q.pop_front());
            if (acc) begin
                p.y = y; p.rd = rd; p.we = w && ps; p.pass = ps;
                m_q.push_back(p);
            end
        end
        if (acc && ps && s) m_nzcv = f;
    endtask

    task automatic idle(input logic ordy);
        tick(1'b0, 32'h0, 4'h0, 4'hE, 1'b0, 1'b0, 4'h0, ordy, 1'b0);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_y = '0; in_flags = '0;
        in_cond = '0; in_setf = 1'b0; in_wb = 1'b0; in_rd = '0; out_ready = 1'b0;
        m_nzcv = 4'b0000;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_out_y", out_y, 32'h0);
        chk("rst_out_rd", 32'(out_rd), 32'h0);
        chk("rst_out_we", 32'(out_we), 32'h0);
        chk("rst_out_pass", 32'(out_pass), 32'h0);
        chk("rst_in_ready", 32'(in_ready), 32'h1);

        // Single packet after reset
        tick(1'b1, 32'h5, 4'b0000, 4'hE, 1'b1, 1'b1, 4'd3, 1'b1, 1'b0);
        #1;
        chk("single_valid", 32'(out_valid), 32'h1);
        chk("single_y", out_y, 32'h5);
        chk("single_rd", 32'(out_rd), 32'h3);
        chk("single_we", 32'(out_we), 32'h1);
        chk("single_nzcv", 32'(nzcv), 32'h0);

        // Conditional chain: A sets Z, B (EQ) writes, C (NE) is suppressed
        tick(1'b1, 32'hA, 4'b0100, 4'hE, 1'b1, 1'b0, 4'd1, 1'b1, 1'b0);
        #1; chk("chain_nzcv", 32'(nzcv), 32'b0100);
        tick(1'b1, 32'hB, 4'b0000, 4'h0, 1'b0, 1'b1, 4'd2, 1'b1, 1'b0);
        #1; chk("chain_b_we", 32'(out_we), 32'h1);
        tick(1'b1, 32'hC, 4'b0000, 4'h1, 1'b0, 1'b1, 4'd4, 1'b1, 1'b0);
        #1; chk("chain_c_we", 32'(out_we), 32'h0);
        chk("chain_c_pass", 32'(out_pass), 32'h0);
        chk("chain_c_y", out_y, 32'hC);

        // Failed condition with setf leaves NZCV alone
        tick(1'b1, 32'h0, 4'b0000, 4'hE, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0);
        tick(1'b1, 32'h7, 4'b1010, 4'h2, 1'b1, 1'b1, 4'd5, 1'b1, 1'b0);
        #1; chk("cs_fail_pass", 32'(out_pass), 32'h0);
        chk("cs_fail_nzcv", 32'(nzcv), 32'h0);
        idle(1'b1);

        // Backpressure: 1 and 2 accepted, 3 held by the producer until space frees
        tick(1'b1, 32'h1, 4'h0, 4'hE, 1'b0, 1'b1, 4'd1, 1'b0, 1'b0);
        tick(1'b1, 32'h2, 4'h0, 4'hE, 1'b0, 1'b1, 4'd2, 1'b0, 1'b0);
        #1; chk("bp_stall_y", out_y, 32'h1);
        chk("bp_in_ready", 32'(in_ready), 32'h0);
        tick(1'b1, 32'h3, 4'h0, 4'hE, 1'b0, 1'b1, 4'd3, 1'b0, 1'b0);
        tick(1'b1, 32'h3, 4'h0, 4'hE, 1'b0, 1'b1, 4'd3, 1'b0, 1'b0);
        #1; chk("bp_stable_y", out_y, 32'h1);
        tick(1'b1, 32'h3, 4'h0, 4'hE, 1'b0, 1'b1, 4'd3, 1'b1, 1'b0);
        #1; chk("bp_second_y", out_y, 32'h2);
        tick(1'b1, 32'h3, 4'h0, 4'hE, 1'b0, 1'b1, 4'd3, 1'b1, 1'b0);
        #1; chk("bp_third_y", out_y, 32'h3);
        idle(1'b1);
        #1; chk("bp_drained", 32'(out_valid), 32'h0);

        // Signed conditions with N=1, V=0, then N=1, V=1
        tick(1'b1, 32'h0, 4'b1000, 4'hE, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0);
        tick(1'b1, 32'h10, 4'h0, 4'hA, 1'b0, 1'b1, 4'd0, 1'b1, 1'b0);
        #1; chk("ge_fail", 32'(out_pass), 32'h0);
        tick(1'b1, 32'h11, 4'h0, 4'hB, 1'b0, 1'b1, 4'd0, 1'b1, 1'b0);
        #1; chk("lt_pass", 32'(out_pass), 32'h1);
        tick(1'b1, 32'h12, 4'h0, 4'hD, 1'b0, 1'b1, 4'd0, 1'b1, 1'b0);
        #1; chk("le_pass", 32'(out_pass), 32'h1);
        tick(1'b1, 32'h13, 4'h0, 4'hC, 1'b0, 1'b1, 4'd0, 1'b1, 1'b0);
        #1; chk("gt_fail", 32'(out_pass), 32'h0);
        tick(1'b1, 32'h0, 4'b1001, 4'hE, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0);
        tick(1'b1, 32'h14, 4'h0, 4'hA, 1'b0, 1'b1, 4'd0, 1'b1, 1'b0);
        #1; chk("ge_pass", 32'(out_pass), 32'h1);
        tick(1'b1, 32'h15, 4'hF, 4'hF, 1'b1, 1'b1, 4'd0, 1'b1, 1'b0);
        #1; chk("nv_fail", 32'(out_pass), 32'h0);
        chk("nv_nzcv", 32'(nzcv), 32'b1001);

        // Flush with output and skid full, concurrent setf input discarded
        tick(1'b1, 32'h21, 4'h0, 4'hE, 1'b0, 1'b1, 4'd1, 1'b0, 1'b0);
        tick(1'b1, 32'h22, 4'h0, 4'hE, 1'b0, 1'b1, 4'd2, 1'b0, 1'b0);
        tick(1'b1, 32'h23, 4'b0110, 4'hE, 1'b1, 1'b1, 4'd3, 1'b0, 1'b1);
        idle(1'b1);
        chk("flush_nzcv", 32'(nzcv), 32'b1001);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            tick(1'($urandom_range(0, 3) != 0), $urandom, 4'($urandom), 4'($urandom),
                 1'($urandom), 1'($urandom), 4'($urandom),
                 1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 19) == 0));
        end

        // Async reset mid-cycle with a full buffer and nonzero flags
        tick(1'b1, 32'h31, 4'b1111, 4'hE, 1'b1, 1'b1, 4'd1, 1'b0, 1'b0);
        tick(1'b1, 32'h32, 4'b1111, 4'hE, 1'b1, 1'b1, 4'd2, 1'b0, 1'b0);
        in_valid = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        chk("arst_nzcv", 32'(nzcv), 32'h0);
        chk("arst_out_valid", 32'(out_valid), 32'h0);
        m_q.delete();
        m_nzcv = 4'b0000;
        @(negedge clk);
        rst = 1'b0;
        idle(1'b1);
        tick(1'b1, 32'h41, 4'h0, 4'hE, 1'b0, 1'b1, 4'd7, 1'b1, 1'b0);
        idle(1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/alu_result_stage.md
Name: alu_result_stage

Overview:
- Stage directly downstream of the 32-bit ALU.
- Captures each ALU result `y` and its `{N,Z,C,V}` flag vector.
- Evaluates the instruction's 4-bit condition code against the committed status register (NZCV).
- Conditionally updates NZCV and forwards a write-back packet through a 2-entry valid/ready buffer (output register plus skid) for full throughput.

Parameters:
- M, 32, data width of ALU result and write-back data.
- R, 4, width of destination register index.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous squash of buffered packets.
- in_valid  in  1  ALU result present.
- in_ready  out  1  stage can accept this cycle.
- in_y  in  M  ALU result.
- in_flags  in  4  ALU flags `{N,Z,C,V}`; bit3=N, bit2=Z, bit1=C, bit0=V.
- in_cond  in  4  condition code.
- in_setf  in  1  update NZCV if the condition passes.
- in_wb  in  1  instruction writes a register.
- in_rd  in  R  destination index.
- out_valid  out  1  packet available.
- out_ready  in  1  consumer takes the packet.
- out_y  out  M  write-back data.
- out_rd  out  R  destination index.
- out_we  out  1  register write enable (`in_wb` AND cond pass).
- out_pass  out  1  condition result of this packet.
- nzcv  out  4  committed status register.

Behaviour:
- Reset (async, rst=1): `nzcv`=4'b0000, `out_valid`=0, skid valid=0, `out_y`=0, `out_rd`=0, `out_we`=0, `out_pass`=0. `in_ready`=1 once rst deasserts.
- Accept: `in_valid & in_ready` at a rising edge.
- `in_ready` = ~skid_valid & ~flush. It is a registered state term and does not depend on `out_ready`.
- Condition evaluation uses `nzcv` as seen in the accept cycle, i.e. including all earlier accepted packets:
  - 0 EQ Z; 1 NE ~Z; 2 CS C; 3 CC ~C; 4 MI N; 5 PL ~N; 6 VS V; 7 VC ~V
  - 8 HI C&~Z; 9 LS ~C|Z; A GE N==V; B LT N!=V; C GT ~Z&(N==V); D LE Z|(N!=V)
  - E AL 1; F NV 0
- On accept with pass & `in_setf`: `nzcv` <= `in_flags` at the same edge. Back-to-back packets see the update with zero bubble.
- Failed-condition packets are not dropped. They propagate with `out_we`=0 and `out_pass`=0, preserving ordering. `out_y` is still carried.
- Buffering, per edge with no flush:
  - If output empty or `out_ready`=1: output loads from skid if skid valid, else from the accepted input, else `out_valid`<=0.
  - If output held (`out_valid & ~out_ready`) and an input is accepted: the input goes to skid.
  - Skid is never written while valid.
- Latency: 1 cycle from accept to `out_valid`. Sustains 1 packet/cycle when `out_ready`=1.
- Output fields are stable while `out_valid & ~out_ready`.
- Flush=1 at an edge:
  - out_valid<=0 and skid valid<=0.
  - No input is accepted (`in_ready`=0), so a concurrent `in_valid` is discarded and `nzcv` is not updated by it.
  - `nzcv` retains its value.
- Flush and `out_ready` together: packet considered consumed. Flush still clears state.
- Reset mid-stream: all buffered packets lost and `nzcv` cleared immediately, without waiting for a clock.
- Data paths are pure pass-through. No arithmetic on `in_y`; width M preserved.

Test Plan:
- Reset then single packet: `in_y`=32'h0000_0005, cond=E, wb=1, setf=1, flags=4'b0000, rd=3, `out_ready`=1 -> next cycle `out_valid`=1, `out_y`=5, `out_rd`=3, `out_we`=1, `nzcv`=0000.
- Conditional chain:
  - Packet A: setf=1, flags=4'b0100 (Z), cond=AL.
  - Packet B, next cycle: cond=0 (EQ), wb=1.
  - Packet C: cond=1 (NE).
  - Required: B `out_we`=1; C `out_we`=0 and `out_pass`=0; `nzcv`=0100 after A.
- Failed cond with setf: `nzcv`=0000, cond=2 (CS), setf=1, flags=4'b1010 -> `nzcv` stays 0000, `out_pass`=0.
- Backpressure: hold `out_ready`=0, drive 3 consecutive valid packets (y=1,2,3).
  - Packets 1 and 2 accepted; `in_ready`=0 from cycle 2; packet 3 held by producer.
  - Release `out_ready`: outputs 1,2,3 in order with no loss or duplication.
  - `out_y` stable while stalled.
- Signed conditions, each with flags loaded by a prior setf packet:
  - flags=4'b1000 (N=1,V=0): GE fails, LT passes, LE passes, GT fails.
  - flags=4'b1001: GE passes.
  - cond=F never passes.
- Flush/reset: with output and skid full, assert flush one cycle with `in_valid`=1 and setf=1 -> `out_valid`=0, `in_ready`=1 next cycle, `nzcv` unchanged. Asserting rst asynchronously mid-cycle -> `nzcv`=0 and `out_valid`=0 before the next clock edge.
